regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register file with NREAD registered read ports, one write port, write-first bypass, hardwired-zero register 0 and a per-register busy scoreboard. It sits between decode and writeback in the RISC-V core. Issue marks a destination register busy, writeback clears it, and decode reads operand data together with the busy flags in the same cycle to decide whether to stall.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NREAD, 2, number of read ports, 1..4
- AW (derived, not overridable), $clog2(NREGS), register address width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- issue_en  in  1  instruction issued with a destination register
- issue_rd  in  AW  destination being issued
- flush  in  1  clear all busy bits (pipeline squash)
- rs_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]
- rs_data  out  NREAD*XLEN  registered read data; port i uses bits [i*XLEN +: XLEN]
- rs_busy  out  NREAD  registered busy flag per read port
- any_busy  out  1  registered; 1 if any busy bit is set

## Operation
- Storage: regs[0..NREGS-1] of XLEN bits, plus busy[0..NREGS-1].
- Register 0 reads as 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Issue: on a rising edge with issue_en=1 and issue_rd≠0, busy[issue_rd] ← 1.
- Issue and write to the same register on the same edge: the register takes the data and busy ends up 1, because the new producer wins.
- flush=1: every busy bit ← 0. flush has priority over issue on the same edge. The write still updates the data.
- Read port i, on each edge:
  - rs_data[i] ← next-state value of regs[rs_addr[i]]. Write-first bypass: if wr_en and wr_addr==rs_addr[i]≠0, the port returns wr_data.
  - rs_busy[i] ← next-state value of busy[rs_addr[i]], after the write, issue and flush of that edge are applied.
- rs_addr[i]=0: rs_data[i] ← 0 and rs_busy[i] ← 0, regardless of any write or issue.
- Multiple ports may read the same address. All of them return identical data and busy flags.
- any_busy ← OR of the next-state busy bits.
- wr_addr and rs_addr values ≥ NREGS cannot occur, because NREGS is a power of two.

## Timing
- Asynchronous reset (rst_n=0): all regs = 0, all busy = 0, rs_data = 0, rs_busy = 0, any_busy = 0.
- Reset deassertion is synchronised outside this block. The first active edge after rst_n rises behaves as a normal cycle.
- Reset asserted mid-operation: contents are lost immediately and outputs go to 0 without waiting for a clock edge.
- Read latency: 1 cycle. rs_addr presented before edge N gives rs_data/rs_busy valid after edge N, stable until edge N+1.
- Write-to-read: a write at edge N is visible on a read sampled at edge N (bypass), so there is 0 added latency.
- Issue-to-busy: an issue at edge N shows rs_busy=1 for a read sampled at edge N.
- Writeback-to-not-busy: a write at edge N shows rs_busy=0 for a read sampled at edge N, unless an issue to the same register happens at that edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset and zero register:
  - Assert rst_n=0 mid-stream: all outputs read 0 within the same cycle.
  - After reset, every address reads 0 and busy=0.
  - Write 0xDEADBEEF to reg 0, then read reg 0: rs_data=0, rs_busy=0.
- Basic write/read and multi-port: with NREAD=2, write 0x11111111 to r5 and 0x22222222 to r6 in two cycles, then read r5 on port 0 and r6 on port 1. The ports return 0x11111111 and 0x22222222 one cycle later. Reading r5 on both ports returns identical values.
- Bypass: on the same edge, write 0xCAFEF00D to r7 and read r7 on both ports. Both ports show 0xCAFEF00D after that edge.
- Scoreboard:
  - Issue r9 at edge N and read r9: rs_busy=1.
  - Write r9=0x5 at edge N+3: rs_busy=0 and rs_data=0x5 after edge N+3.
- Simultaneous events:
  - Issue and write r12 on the same edge: data updates and rs_busy=1.
  - Issue r3 with flush=1: busy[r3]=0 and any_busy=0.
  - Issue r1..r31, then flush: any_busy goes 1→0 after one edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD registered read ports, write-first bypass and a busy scoreboard.
// Read latency 1 cycle, no backpressure: every port accepts an address every cycle.
module regfile_scoreboard #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  output logic                  any_busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_ok;
  logic             issue_ok;

  logic [AW-1:0]    ra      [NREAD];
  logic [XLEN-1:0]  rd_nxt  [NREAD];
  logic [NREAD-1:0] rb_nxt;

  assign wr_ok    = wr_en && (wr_addr != '0);
  assign issue_ok = issue_en && (issue_rd != '0);

  // Order matters: writeback clears, a same-edge issue re-sets, flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (issue_ok) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_ra
    assign ra[i] = rs_addr[i*AW +: AW];
  end

  // Ports sample the state as it will be after this edge, so writes bypass straight through.
  always_comb begin
    rb_nxt = '0;
    for (int p = 0; p < NREAD; p++) begin
      rd_nxt[p] = '0;
      if (ra[p] != '0) begin
        if (wr_ok && (wr_addr == ra[p])) begin
          rd_nxt[p] = wr_data;
        end else begin
          rd_nxt[p] = regs[ra[p]];
        end
      end
      rb_nxt[p] = busy_nxt[ra[p]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      rs_data  <= '0;
      rs_busy  <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      rs_busy  <= rb_nxt;
      any_busy <= |busy_nxt;
      for (int p = 0; p < NREAD; p++) begin
        rs_data[p*XLEN +: XLEN] <= rd_nxt[p];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  wr_en = 1'b0;
  logic [AW-1:0]         wr_addr = '0;
  logic [XLEN-1:0]       wr_data = '0;
  logic                  issue_en = 1'b0;
  logic [AW-1:0]         issue_rd = '0;
  logic                  flush = 1'b0;
  logic [NREAD*AW-1:0]   rs_addr = '0;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  any_busy;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .rs_addr(rs_addr),
    .rs_data(rs_data), .rs_busy(rs_busy), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic bit model_any();
    bit a = 1'b0;
    for (int r = 0; r < NREGS; r++) a |= m_busy[r];
    return a;
  endfunction

  // Apply one clock edge with the given inputs, advance the model, then check every output.
  task automatic step(input bit we, input int wa, input logic [XLEN-1:0] wd,
                      input bit ie, input int ir, input bit fl,
                      input int a0, input int a1, input string tag);
    int a [NREAD];
    a[0] = a0;
    a[1] = a1;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    issue_en = ie;
    issue_rd = AW'(ir);
    flush    = fl;
    rs_addr  = {AW'(a1), AW'(a0)};
    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (ie && ir != 0) m_busy[ir] = 1'b1;
    if (fl) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    #1;
    for (int p = 0; p < NREAD; p++) begin
      chk($sformatf("%s data%0d", tag, p), 64'(rs_data[p*XLEN +: XLEN]), 64'(m_regs[a[p]]));
      chk($sformatf("%s busy%0d", tag, p), 64'(rs_busy[p]), 64'(m_busy[a[p]]));
    end
    chk($sformatf("%s any_busy", tag), 64'(any_busy), 64'(model_any()));
  endtask

  task automatic idle_read(input int a0, input int a1, input string tag);
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, a0, a1, tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset rs_data", 64'(rs_data), 64'd0);
    chk("reset rs_busy", 64'(rs_busy), 64'd0);
    chk("reset any_busy", 64'(any_busy), 64'd0);
    rst_n = 1'b1;

    for (int r = 0; r < NREGS; r += 2) idle_read(r, r + 1, "post-reset");

    step(1'b1, 0, 32'hDEADBEEF, 1'b1, 0, 1'b0, 0, 0, "r0 write");
    idle_read(0, 0, "r0 read");

    step(1'b1, 5, 32'h11111111, 1'b0, 0, 1'b0, 0, 0, "wr r5");
    step(1'b1, 6, 32'h22222222, 1'b0, 0, 1'b0, 0, 0, "wr r6");
    idle_read(5, 6, "rd r5 r6");
    chk("r5 literal", 64'(rs_data[0 +: XLEN]), 64'h11111111);
    chk("r6 literal", 64'(rs_data[XLEN +: XLEN]), 64'h22222222);
    idle_read(5, 5, "rd r5 both");

    step(1'b1, 7, 32'hCAFEF00D, 1'b0, 0, 1'b0, 7, 7, "bypass r7");
    chk("bypass literal", 64'(rs_data[XLEN +: XLEN]), 64'hCAFEF00D);

    step(1'b0, 0, '0, 1'b1, 9, 1'b0, 9, 0, "issue r9");
    chk("issue r9 busy", 64'(rs_busy[0]), 64'd1);
    idle_read(9, 9, "r9 wait1");
    idle_read(9, 9, "r9 wait2");
    step(1'b1, 9, 32'h5, 1'b0, 0, 1'b0, 9, 9, "wb r9");
    chk("wb r9 busy", 64'(rs_busy[0]), 64'd0);

    step(1'b1, 12, 32'hA5A5A5A5, 1'b1, 12, 1'b0, 12, 0, "issue+wb r12");
    chk("r12 busy", 64'(rs_busy[0]), 64'd1);
    step(1'b1, 12, 32'h0, 1'b0, 0, 1'b1, 12, 0, "clear r12");

    step(1'b0, 0, '0, 1'b1, 3, 1'b1, 3, 0, "issue r3 flush");
    chk("flush any_busy", 64'(any_busy), 64'd0);

    for (int r = 1; r < NREGS; r++) step(1'b0, 0, '0, 1'b1, r, 1'b0, r, 0, "issue all");
    chk("all busy", 64'(any_busy), 64'd1);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1, 31, 1, "flush all");
    chk("flush all any_busy", 64'(any_busy), 64'd0);

    for (int n = 0; n < 600; n++) begin
      int sel = $urandom_range(0, 99);
      step($urandom_range(0, 1), $urandom_range(0, NREGS - 1), $urandom,
           (sel < 60), $urandom_range(0, NREGS - 1), (sel > 95),
           (sel % 7 == 0) ? 0 : $urandom_range(0, NREGS - 1),
           $urandom_range(0, NREGS - 1), "random");
      if (n == 300) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midreset rs_data", 64'(rs_data), 64'd0);
        chk("midreset rs_busy", 64'(rs_busy), 64'd0);
        chk("midreset any_busy", 64'(any_busy), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        idle_read(5, 9, "after midreset");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
